// File: rtl/popcount_pkg.sv
// Shared types and widths for the popcount arbiter slice.
package popcount_pkg;
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;
  localparam int OPND_W = 127;
  localparam int CNT_W  = 7;
endpackage

// File: rtl/onescount127bit.sv
// Purely combinational ones counter over one 127-bit operand.
module onescount127bit
  import popcount_pkg::*;
(
  input  logic [OPND_W-1:0] opnd,
  output logic [CNT_W-1:0]  cnt
);

  // Sum of all operand bits; 127 ones fits exactly in 7 bits.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < OPND_W; i++) cnt = cnt + CNT_W'(opnd[i]);
  end

endmodule

// File: rtl/popcount_arbiter.sv
// Round-robin arbiter sharing one registered-operand popcount datapath.
module popcount_arbiter
  import popcount_pkg::*;
#(
  parameter int NREQ   = 4,
  parameter int SETTLE = 3
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NREQ-1:0]          req,
  input  logic [NREQ*OPND_W-1:0]   data,
  output logic [NREQ-1:0]          gnt,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(NREQ)-1:0]  done_id,
  output logic [CNT_W-1:0]         count
);

  localparam int IDW = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [NREQ-1:0]   gnt_q, gnt_d;
  logic [OPND_W-1:0] operand_q, operand_d;
  logic [3:0]        timer_q, timer_d;
  logic [IDW-1:0]    last_q, last_d;
  logic [IDW-1:0]    gidx_q, gidx_d;
  logic [IDW-1:0]    done_id_q, done_id_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              done_q, done_d;

  logic              win_found;
  logic [IDW-1:0]    win_idx;
  logic [CNT_W-1:0]  pc;

  // The datapath only ever sees the latched operand, so late data changes cannot leak in.
  onescount127bit u_cnt (
    .opnd (operand_q),
    .cnt  (pc)
  );

  // Round-robin pick: first requester above the last grant, wrapping.
  always_comb begin
    win_found = 1'b0;
    win_idx   = last_q;
    for (int k = 1; k <= NREQ; k++) begin
      if (!win_found && req[(int'(last_q) + k) % NREQ]) begin
        win_found = 1'b1;
        win_idx   = IDW'((int'(last_q) + k) % NREQ);
      end
    end
  end

  // Next-state logic: grant and latch in IDLE, count down in BUSY, report on the way to DONE.
  always_comb begin
    state_d   = state_q;
    gnt_d     = gnt_q;
    operand_d = operand_q;
    timer_d   = timer_q;
    last_d    = last_q;
    gidx_d    = gidx_q;
    done_id_d = done_id_q;
    count_d   = count_q;
    done_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (win_found) begin
          state_d   = BUSY;
          gnt_d     = NREQ'(1) << win_idx;
          gidx_d    = win_idx;
          last_d    = win_idx;
          operand_d = data[int'(win_idx)*OPND_W +: OPND_W];
          timer_d   = 4'(SETTLE - 1);
        end
      end
      BUSY: begin
        if (timer_q == '0) begin
          state_d   = DONE;
          count_d   = pc;
          done_id_d = gidx_q;
          done_d    = 1'b1;
        end else begin
          timer_d = timer_q - 4'd1;
        end
      end
      DONE: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register; reset wins over everything and leaves requester 0 next in line.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      gnt_q     <= '0;
      operand_q <= '0;
      timer_q   <= '0;
      last_q    <= IDW'(NREQ - 1);
      gidx_q    <= '0;
      done_id_q <= '0;
      count_q   <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      gnt_q     <= gnt_d;
      operand_q <= operand_d;
      timer_q   <= timer_d;
      last_q    <= last_d;
      gidx_q    <= gidx_d;
      done_id_q <= done_id_d;
      count_q   <= count_d;
      done_q    <= done_d;
    end
  end

  assign gnt     = gnt_q;
  assign busy    = (state_q != IDLE);
  assign done    = done_q;
  assign done_id = done_id_q;
  assign count   = count_q;

endmodule

// File: tb/tb_popcount_arbiter.sv
// Directed bench for popcount_arbiter with NREQ=4, SETTLE=3.
module tb_popcount_arbiter;
  localparam int NREQ   = 4;
  localparam int SETTLE = 3;
  localparam int W      = 127;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [NREQ-1:0]    req;
  logic [NREQ*W-1:0]  data;
  logic [NREQ-1:0]    gnt;
  logic               busy;
  logic               done;
  logic [1:0]         done_id;
  logic [6:0]         count;

  int n_run  = 0;
  int n_fail = 0;

  popcount_arbiter #(.NREQ(NREQ), .SETTLE(SETTLE)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .req     (req),
    .data    (data),
    .gnt     (gnt),
    .busy    (busy),
    .done    (done),
    .done_id (done_id),
    .count   (count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_run++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d want %0d", tag, obs, exp);
    end
  endtask

  // Waits (sampling at negedges) for done; n = edges elapsed since the last sample.
  task automatic wait_done(input int max, output int n);
    n = 0;
    while (done !== 1'b1 && n < max) begin
      @(negedge clk);
      n++;
    end
  endtask

  // Synchronous reset for one edge, then release with req idle.
  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    req   = '0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Runs a window of cycles with req held, logging each done pulse.
  task automatic collect(input int cycles, output int ids[$], output int cnts[$],
                         output int when[$], output logic bad_gnt);
    ids = {}; cnts = {}; when = {};
    bad_gnt = 1'b0;
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        ids.push_back(int'(done_id));
        cnts.push_back(int'(count));
        when.push_back(c);
      end
      if (gnt[1] === 1'b1 || gnt[3] === 1'b1) bad_gnt = 1'b1;
    end
  endtask

  initial begin
    int   n;
    int   ids[$], cnts[$], when[$];
    logic bad;
    logic seen;

    rst_n = 1'b0;
    req   = '0;
    data  = '0;

    // Reset held two edges with every requester asking.
    @(negedge clk);
    req = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rst_gnt",   32'(gnt),   0);
      chk("rst_busy",  32'(busy),  0);
      chk("rst_done",  32'(done),  0);
      chk("rst_count", 32'(count), 0);
    end

    // Single request, all-ones operand.
    rst_n = 1'b1;
    req   = 4'b0001;
    data[0 +: W] = {W{1'b1}};
    @(posedge clk);
    @(negedge clk);
    chk("single_gnt",  32'(gnt),  1);
    chk("single_busy", 32'(busy), 1);
    req = '0;
    wait_done(20, n);
    chk("single_done_seen", 32'(done), 1);
    chk("single_latency",   n, SETTLE);
    chk("single_count",     32'(count), 127);
    chk("single_id",        32'(done_id), 0);
    chk("single_gnt_in_done", 32'(gnt), 1);
    @(negedge clk);
    chk("single_done_pulse", 32'(done), 0);
    chk("single_gnt_clear",  32'(gnt), 0);
    chk("single_busy_clear", 32'(busy), 0);
    chk("single_count_hold", 32'(count), 127);

    // Contention: popcounts 1,2,3,4; each operation spans IDLE+SETTLE+DONE = SETTLE+2 cycles.
    do_reset();
    data[0*W +: W] = W'(1);
    data[1*W +: W] = W'(3);
    data[2*W +: W] = W'(7);
    data[3*W +: W] = W'(15);
    req = 4'b1111;
    collect(20, ids, cnts, when, bad);
    req = '0;
    chk("cont_ndone", ids.size(), 4);
    if (ids.size() >= 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("cont_id%0d", i),    ids[i],  i);
        chk($sformatf("cont_count%0d", i), cnts[i], i + 1);
      end
      for (int i = 1; i < 4; i++)
        chk($sformatf("cont_gap%0d", i), when[i] - when[i-1], SETTLE + 2);
    end

    // Fairness between requesters 0 and 2.
    do_reset();
    req = 4'b0101;
    collect(20, ids, cnts, when, bad);
    req = '0;
    chk("fair_ndone", ids.size(), 4);
    if (ids.size() >= 4) begin
      chk("fair_id0", ids[0], 0);
      chk("fair_id1", ids[1], 2);
      chk("fair_id2", ids[2], 0);
      chk("fair_id3", ids[3], 2);
    end
    chk("fair_no_gnt13", 32'(bad), 0);

    // Hold-off: operand and req changes after grant must not matter.
    do_reset();
    data[1*W +: W] = W'(8'h0F);
    req = 4'b0010;
    @(posedge clk);
    @(negedge clk);
    chk("hold_gnt", 32'(gnt), 2);
    data[1*W +: W] = {W{1'b1}};
    req = '0;
    wait_done(20, n);
    chk("hold_done_seen", 32'(done), 1);
    chk("hold_count",     32'(count), 4);
    chk("hold_id",        32'(done_id), 1);

    // Abort mid-BUSY, then requester 0 must win first.
    do_reset();
    data[3*W +: W] = {W{1'b1}};
    req = 4'b1000;
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt", 32'(gnt), 8);
    rst_n = 1'b0;
    req   = '0;
    @(posedge clk);
    @(negedge clk);
    chk("abort_gnt_rst",   32'(gnt), 0);
    chk("abort_busy_rst",  32'(busy), 0);
    chk("abort_done_rst",  32'(done), 0);
    chk("abort_count_rst", 32'(count), 0);
    chk("abort_id_rst",    32'(done_id), 0);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done === 1'b1) seen = 1'b1;
    end
    chk("abort_no_done", 32'(seen), 0);
    data[0*W +: W] = W'(5);
    req = 4'b1001;
    @(posedge clk);
    @(negedge clk);
    chk("abort_fresh_gnt", 32'(gnt), 1);
    req = '0;
    wait_done(20, n);
    chk("abort_fresh_done",  32'(done), 1);
    chk("abort_fresh_count", 32'(count), 2);

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule
